mm_outer_sched: RTL
===================

// Module: mm_outer_sched
// PURPOSE
//  Outer-loop scheduler for the radix-108 Montgomery multiplier. Latches operand B, slices it into RADIX-bit digits
//  LSB-first, feeds one digit bi per pass to inner_loop_new (en/en_out), and hands each pass result to the downstream
//  accumulator/reduction stage over a valid/ready handshake. Sits between the top-level modexp FSM and the inner loop.
// PARAMETERS
//  SIZE        3072  operand width in bits
//  RADIX       108   digit width; equals inner-loop radix
//  NUM_DIGITS  29    passes per product = ceil((SIZE+2)/RADIX)
//  TIMEOUT     15    max cycles in WAIT before error
// PORTS
//  clk        in   1            clock, all flops rising edge
//  rst        in   1            asynchronous, active-high reset
//  start      in   1            1-cycle pulse: begin a product; sampled only in IDLE
//  b          in   SIZE+2       operand B; captured on accepted start
//  busy       out  1            high from accepted start until done/err cycle inclusive
//  done       out  1            1-cycle pulse after last digit's handshake completes
//  err        out  1            1-cycle pulse on inner-loop timeout
//  il_en      out  1            1-cycle pulse to inner_loop_new.en
//  il_bi      out  RADIX        digit to inner_loop_new.bi; stable from il_en until leaving HAND
//  il_en_out  in   1            inner_loop_new.en_out (level; stays high until next en)
//  acc_valid  out  1            pass result (r0/r1) ready for accumulator
//  acc_ready  in   1            accumulator accepts
//  acc_last   out  1            qualifies acc_valid: final digit
//  digit_idx  out  5            index of digit in flight, 0..NUM_DIGITS-1
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy,done,err,il_en,acc_valid,acc_last=0; il_bi=0; digit_idx=0; b_sh=0; wd=0.
//  States: IDLE, ISSUE, GUARD, WAIT, HAND, FIN, ERR.
//  IDLE : start=1 -> b_sh<=b, digit_idx<=0, busy<=1, ->ISSUE. Other inputs ignored.
//  ISSUE: il_en=1 for exactly this cycle; il_bi=b_sh[RADIX-1:0]; ->GUARD.
//  GUARD: one cycle; il_en_out ignored (stale high from previous pass); wd<=0; ->WAIT.
//  WAIT : wd++ each cycle. il_en_out=1 -> ->HAND. wd==TIMEOUT-1 and il_en_out=0 -> ->ERR.
//         Nominal: ISSUE to HAND = 5 cycles (inner loop 4-cycle latency + guard).
//  HAND : acc_valid=1 (acc_last=1 iff digit_idx==NUM_DIGITS-1); hold until acc_ready=1.
//         On valid&ready: if last -> FIN; else b_sh<=b_sh>>RADIX, digit_idx++, ->ISSUE.
//         acc_ready while acc_valid=0 is ignored; acc_valid never drops without ready.
//  FIN  : done=1 one cycle; busy=1 this cycle; ->IDLE (busy=0 next).
//  ERR  : err=1 one cycle; busy=1 this cycle; ->IDLE. No acc_valid issued for the failed digit.
//  Digit slicing: b_sh SIZE+2 bits, logical right shift, zero fill; last digit (idx 28) = b[3073:3024] zero-
//  extended to 108 bits. Upper 58 bits of final il_bi must be 0.
//  start while busy: ignored, no effect on state or b_sh. start in FIN/ERR cycle: ignored.
//  il_en never asserted outside ISSUE; at most one pass in flight. Back-to-back passes: HAND->ISSUE
//  with no bubble. Min product time = NUM_DIGITS*6 + 1 cycles with acc_ready tied high.
//  All outputs registered (Moore); no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package mm_pkg: SIZE, RADIX, NUM_DIGITS, digit-index width, state enum mm_sched_state_t.
//  Single module; watchdog counter inline (no sub-module). Digit shifter is the only wide datapath.
// TESTING
//  T1 b=1, acc_ready=1, model inner loop 4-cycle -> il_bi: 1 then 0 x28; 29 il_en pulses; done at cycle 175.
//  T2 b=all-ones -> il_bi all-ones for idx 0..27, idx 28 = {58'b0,50'h3FFFF_FFFF_FFFF}; acc_last only on idx 28.
//  T3 acc_ready low 10 cycles in HAND idx 3 -> acc_valid,il_bi,digit_idx held; no il_en until ready.
//  T4 inner model never raises en_out on idx 7 -> err pulse 15 cycles after GUARD, busy drops, no done.
//  T5 en_out held high from prior pass, start again -> GUARD ignores it; HAND not entered before 4-cycle latency.
//  T6 rst asserted mid-WAIT idx 12, then start -> all outputs zero immediately; new product runs from idx 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the radix-108 Montgomery multiplier outer-loop scheduler.
// Operand geometry, digit-index and watchdog widths, and the scheduler state type.
package mm_pkg;

    localparam int unsigned SIZE       = 3072;
    localparam int unsigned B_W        = SIZE + 2;
    localparam int unsigned RADIX      = 108;
    localparam int unsigned NUM_DIGITS = (B_W + RADIX - 1) / RADIX;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned TIMEOUT    = 15;
    localparam int unsigned WD_W       = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_HAND,
        S_FIN,
        S_ERR
    } mm_sched_state_t;

endpackage

// File: rtl/mm_outer_sched.sv
// Outer-loop scheduler for the radix-108 Montgomery multiplier.
// Latches operand B on an accepted start, slices it LSB-first into RADIX-bit
// digits, issues one digit per pass to the inner loop and hands each pass
// result to the accumulator over a valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a product (sampled only in IDLE)
//   b          operand B, captured on accepted start
//   busy       high from accepted start through the done/err cycle
//   done       one-cycle pulse after the final digit handshake
//   err        one-cycle pulse on inner-loop timeout
//   il_en      one-cycle pulse to the inner loop
//   il_bi      digit for the inner loop
//   il_en_out  inner-loop completion level
//   acc_valid  pass result available to the accumulator
//   acc_ready  accumulator accepts
//   acc_last   qualifies acc_valid: final digit
//   digit_idx  index of the digit in flight
module mm_outer_sched
    import mm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [B_W-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             il_en,
    output logic [RADIX-1:0] il_bi,
    input  logic             il_en_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             acc_last,
    output logic [IDX_W-1:0] digit_idx
);

    mm_sched_state_t  state_q, state_d;
    logic [B_W-1:0]   b_sh_q, b_sh_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic en_q, en_d;
    logic valid_q, valid_d;
    logic last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_sh_q  <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_sh_q  <= b_sh_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_sh_d  = b_sh_q;
        idx_d   = idx_q;
        wd_d    = wd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_sh_d  = b;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: begin
                // en_out may still be high from the previous pass; not looked at here.
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (il_en_out) begin
                    state_d = S_HAND;
                end else if (wd_q == WD_LIMIT) begin
                    state_d = S_ERR;
                end
            end
            S_HAND: begin
                if (acc_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                    end else begin
                        b_sh_d  = b_sh_q >> RADIX;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FIN);
        err_d   = (state_d == S_ERR);
        en_d    = (state_d == S_ISSUE);
        valid_d = (state_d == S_HAND);
        last_d  = (state_d == S_HAND) && (idx_d == LAST_IDX);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign il_en     = en_q;
    assign il_bi     = b_sh_q[RADIX-1:0];
    assign acc_valid = valid_q;
    assign acc_last  = last_q;
    assign digit_idx = idx_q;

endmodule
